// File: rtl/cfu_crc_pkg.sv
// Shared types and the CRC table generator for the CFU CRC unit.
package cfu_crc_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } crc_state_t;

    typedef logic [255:0][31:0] crc_tab_t;

    // Build the 256-entry lookup table for a reflected CRC-32 polynomial.
    function automatic crc_tab_t gen_crc_table(input logic [31:0] poly);
        crc_tab_t    tab;
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int b = 0; b < 8; b++) begin
                if (c[0]) begin
                    c = {1'b0, c[31:1]} ^ poly;
                end else begin
                    c = {1'b0, c[31:1]};
                end
            end
            tab[i] = c;
        end
        return tab;
    endfunction

endpackage

// File: rtl/cfu_interface.sv
// Request/response channel between a CPU custom-function port and a unit.
interface cfu_interface;
    import cfu_crc_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [DATA_W-1:0] resp_data;
    logic              resp_status;

    modport unit (
        input  req_valid, req_id, req_data0, req_data1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_status
    );

endinterface

// File: rtl/cfu_crc_byte_fold.sv
// Folds one byte into a running reflected CRC-32 through the lookup table.
module cfu_crc_byte_fold
    import cfu_crc_pkg::*;
#(
    parameter logic [31:0] POLY = 32'hEDB88320
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_out
);

    localparam crc_tab_t TAB = gen_crc_table(POLY);

    logic [7:0] idx_s;

    assign idx_s   = crc_in[7:0] ^ data_byte;
    assign crc_out = TAB[idx_s] ^ {8'h00, crc_in[31:8]};

endmodule

// File: rtl/cfu_crc_unit.sv
// CFU CRC-32 unit: accepts a data word plus running CRC, folds NBYTES bytes
// (LSB first) at BYTES_PER_CYCLE per clock, and returns the updated CRC.
module cfu_crc_unit
    import cfu_crc_pkg::*;
#(
    parameter logic [31:0] POLY            = 32'hEDB88320,
    parameter int          NBYTES          = 4,
    parameter int          BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    cfu_interface.unit   cfu
);

    localparam int CNT_W = $clog2(NBYTES) + 1;

    if ((NBYTES < 1) || (NBYTES > 4)) begin : g_bad_nbytes
        $error("cfu_crc_unit: NBYTES must be 1..4");
    end
    if ((BYTES_PER_CYCLE != 1) && (BYTES_PER_CYCLE != 2) && (BYTES_PER_CYCLE != 4)) begin : g_bad_bpc
        $error("cfu_crc_unit: BYTES_PER_CYCLE must be 1, 2 or 4");
    end
    if ((NBYTES % BYTES_PER_CYCLE) != 0) begin : g_bad_div
        $error("cfu_crc_unit: BYTES_PER_CYCLE must divide NBYTES");
    end

    crc_state_t        state_r;
    crc_state_t        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              calc_done_s;
    logic [31:0]       crc_r;
    logic [31:0]       data_r;
    logic [ID_W-1:0]   id_r;
    logic              resp_valid_r;
    logic [31:0]       resp_data_r;
    logic [ID_W-1:0]   resp_id_r;
    logic [31:0]       chain_s [BYTES_PER_CYCLE+1];

    // Fold chain: each stage consumes the next-higher byte of the data shifter.
    assign chain_s[0] = crc_r;
    for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_fold
        cfu_crc_byte_fold #(.POLY(POLY)) u_fold (
            .crc_in    (chain_s[k]),
            .data_byte (data_r[8*k +: 8]),
            .crc_out   (chain_s[k+1])
        );
    end

    assign cnt_next_s = cnt_r + CNT_W'(BYTES_PER_CYCLE);

    // Last CALC cycle once this step's bytes bring the count to NBYTES.
    always_comb begin
        calc_done_s = 1'b0;
        if (cnt_next_s == CNT_W'(NBYTES)) begin
            calc_done_s = 1'b1;
        end else begin
            calc_done_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> CALC -> RESP -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfu.req_valid) state_next_s = ST_CALC;
                else               state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (calc_done_s) state_next_s = ST_RESP;
                else             state_next_s = ST_CALC;
            end
            ST_RESP: begin
                if (cfu.resp_ready) state_next_s = ST_IDLE;
                else                state_next_s = ST_RESP;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: capture request, fold bytes, hold the response until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r        <= '0;
            crc_r        <= 32'h0000_0000;
            data_r       <= 32'h0000_0000;
            id_r         <= '0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            resp_id_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfu.req_valid) begin
                        id_r   <= cfu.req_id;
                        data_r <= cfu.req_data0;
                        crc_r  <= cfu.req_data1;
                        cnt_r  <= '0;
                    end
                end
                ST_CALC: begin
                    crc_r  <= chain_s[BYTES_PER_CYCLE];
                    data_r <= data_r >> (8 * BYTES_PER_CYCLE);
                    cnt_r  <= cnt_next_s;
                    if (calc_done_s) begin
                        resp_valid_r <= 1'b1;
                        resp_data_r  <= chain_s[BYTES_PER_CYCLE];
                        resp_id_r    <= id_r;
                    end
                end
                ST_RESP: begin
                    if (cfu.resp_ready) begin
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cfu.req_ready   = (state_r == ST_IDLE);
    assign cfu.resp_valid  = resp_valid_r;
    assign cfu.resp_data   = resp_data_r;
    assign cfu.resp_id     = resp_id_r;
    assign cfu.resp_status = 1'b0;

endmodule

// File: tb/tb_cfu_crc_unit.sv
// Directed bench for cfu_crc_unit: three instances cover NBYTES=1,
// NBYTES=4 one-byte-per-cycle (defaults) and NBYTES=4 four-bytes-per-cycle.
module tb_cfu_crc_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic        iv     [3];
    logic [7:0]  id_i   [3];
    logic [31:0] d0_i   [3];
    logic [31:0] d1_i   [3];
    logic        rr     [3];
    logic        rq     [3];
    logic        rv     [3];
    logic [7:0]  rsp_id [3];
    logic [31:0] rd     [3];
    logic        rs     [3];

    cfu_interface c0();
    cfu_interface c1();
    cfu_interface c2();

    assign c0.req_valid = iv[0]; assign c0.req_id = id_i[0]; assign c0.req_data0 = d0_i[0];
    assign c0.req_data1 = d1_i[0]; assign c0.resp_ready = rr[0];
    assign c1.req_valid = iv[1]; assign c1.req_id = id_i[1]; assign c1.req_data0 = d0_i[1];
    assign c1.req_data1 = d1_i[1]; assign c1.resp_ready = rr[1];
    assign c2.req_valid = iv[2]; assign c2.req_id = id_i[2]; assign c2.req_data0 = d0_i[2];
    assign c2.req_data1 = d1_i[2]; assign c2.resp_ready = rr[2];

    assign rq[0] = c0.req_ready; assign rv[0] = c0.resp_valid; assign rsp_id[0] = c0.resp_id;
    assign rd[0] = c0.resp_data; assign rs[0] = c0.resp_status;
    assign rq[1] = c1.req_ready; assign rv[1] = c1.resp_valid; assign rsp_id[1] = c1.resp_id;
    assign rd[1] = c1.resp_data; assign rs[1] = c1.resp_status;
    assign rq[2] = c2.req_ready; assign rv[2] = c2.resp_valid; assign rsp_id[2] = c2.resp_id;
    assign rd[2] = c2.resp_data; assign rs[2] = c2.resp_status;

    cfu_crc_unit #(.NBYTES(1), .BYTES_PER_CYCLE(1)) dut_n1 (.clk(clk), .rst(rst), .cfu(c0));
    cfu_crc_unit #(.NBYTES(4), .BYTES_PER_CYCLE(4)) dut_n4w (.clk(clk), .rst(rst), .cfu(c1));
    cfu_crc_unit dut_def (.clk(clk), .rst(rst), .cfu(c2));

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response on instance w; lat counts cycles from accept.
    task automatic transact(input int w, input logic [7:0] id, input logic [31:0] d0,
                            input logic [31:0] d1, input int lat, output logic [31:0] res);
        int n;
        check_eq("req_ready_idle", 32'(rq[w]), 32'd1);
        iv[w] = 1'b1; id_i[w] = id; d0_i[w] = d0; d1_i[w] = d1; rr[w] = 1'b0;
        @(posedge clk); #1;
        iv[w] = 1'b0;
        n = 1;
        while (!rv[w] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'(lat));
        check_eq("resp_valid", 32'(rv[w]), 32'd1);
        check_eq("resp_id", 32'(rsp_id[w]), 32'(id));
        check_eq("resp_status", 32'(rs[w]), 32'd0);
        res = rd[w];
        rr[w] = 1'b1;
        @(posedge clk); #1;
        rr[w] = 1'b0;
        check_eq("resp_valid_clear", 32'(rv[w]), 32'd0);
        check_eq("req_ready_after", 32'(rq[w]), 32'd1);
    endtask

    initial begin
        logic [31:0] crc;
        int          hits;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; id_i[i] = 8'h00; d0_i[i] = 32'h0; d1_i[i] = 32'h0; rr[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_resp_valid", 32'(rv[i]), 32'd0);
            check_eq("rst_resp_data", rd[i], 32'h0);
            check_eq("rst_resp_id", 32'(rsp_id[i]), 32'd0);
        end
        rst = 1'b1;
        check_eq("ready_after_rst", 32'(rq[2]), 32'd1);

        // Single-byte vectors.
        transact(0, 8'h01, 32'h0000_0001, 32'h0000_0000, 2, crc);
        check_eq("crc_byte01", crc, 32'h7707_3096);
        transact(0, 8'h02, 32'h0000_0000, 32'hFFFF_FFFF, 2, crc);
        check_eq("crc_byte00_ff", crc, 32'h2DFD_1072);

        // "123456789" one byte per request.
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            transact(0, 8'(8'h20 + i), 32'(32'h31 + i), crc, 2, crc);
        end
        check_eq("crc_check_n1", crc, 32'h340B_C6D9);

        // Same string as two words on the wide instance, then the last byte.
        crc = 32'hFFFF_FFFF;
        transact(1, 8'h40, 32'h3433_3231, crc, 2, crc);
        transact(1, 8'h41, 32'h3837_3635, crc, 2, crc);
        transact(0, 8'h42, 32'h0000_0039, crc, 2, crc);
        check_eq("crc_check_n4w", crc, 32'h340B_C6D9);

        // Default instance: four zero bytes, then the string again.
        transact(2, 8'h50, 32'h0000_0000, 32'hFFFF_FFFF, 5, crc);
        check_eq("crc_zero4", crc, 32'hDEBB_20E3);
        crc = 32'hFFFF_FFFF;
        transact(2, 8'h51, 32'h3433_3231, crc, 5, crc);
        transact(2, 8'h52, 32'h3837_3635, crc, 5, crc);
        transact(0, 8'h53, 32'h0000_0039, crc, 2, crc);
        check_eq("crc_check_def", crc, 32'h340B_C6D9);

        // Stall in RESP with a second request pulsed in the middle.
        iv[0] = 1'b1; id_i[0] = 8'h55; d0_i[0] = 32'h1; d1_i[0] = 32'h0; rr[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int i = 0; i < 10 && !rv[0]; i++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                iv[0] = 1'b1; id_i[0] = 8'h66; d0_i[0] = 32'h0; d1_i[0] = 32'hFFFF_FFFF;
            end else begin
                iv[0] = 1'b0;
            end
            @(posedge clk); #1;
            check_eq("stall_valid", 32'(rv[0]), 32'd1);
            check_eq("stall_ready", 32'(rq[0]), 32'd0);
            check_eq("stall_data", rd[0], 32'h7707_3096);
            check_eq("stall_id", 32'(rsp_id[0]), 32'h55);
        end
        iv[0] = 1'b0;
        rr[0] = 1'b1;
        @(posedge clk); #1;
        rr[0] = 1'b0;
        check_eq("stall_release", 32'(rv[0]), 32'd0);
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv[0]) hits++;
        end
        check_eq("ignored_req_resp", 32'(hits), 32'd0);

        // Reset in the middle of CALC on the default instance.
        iv[2] = 1'b1; id_i[2] = 8'h77; d0_i[2] = 32'h1234_5678; d1_i[2] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("abort_valid", 32'(rv[2]), 32'd0);
        check_eq("abort_ready", 32'(rq[2]), 32'd1);
        check_eq("abort_data", rd[2], 32'h0);
        check_eq("abort_id", 32'(rsp_id[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("abort_ready_rel", 32'(rq[2]), 32'd1);
        hits = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rv[2]) hits++;
        end
        check_eq("abort_no_stale", 32'(hits), 32'd0);
        transact(2, 8'h78, 32'h0000_0000, 32'hFFFF_FFFF, 5, crc);
        check_eq("abort_recover", crc, 32'hDEBB_20E3);

        // Back-to-back with req_valid held across the response handshake.
        iv[0] = 1'b1; id_i[0] = 8'h10; d0_i[0] = 32'h1; d1_i[0] = 32'h0; rr[0] = 1'b1;
        @(posedge clk); #1;
        id_i[0] = 8'h11; d0_i[0] = 32'h0; d1_i[0] = 32'hFFFF_FFFF;
        check_eq("b2b_calc_ready", 32'(rq[0]), 32'd0);
        @(posedge clk); #1;
        check_eq("b2b_first_valid", 32'(rv[0]), 32'd1);
        check_eq("b2b_first_id", 32'(rsp_id[0]), 32'h10);
        check_eq("b2b_first_data", rd[0], 32'h7707_3096);
        @(posedge clk); #1;
        check_eq("b2b_idle_ready", 32'(rq[0]), 32'd1);
        check_eq("b2b_idle_valid", 32'(rv[0]), 32'd0);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check_eq("b2b_second_accept", 32'(rq[0]), 32'd0);
        @(posedge clk); #1;
        check_eq("b2b_second_valid", 32'(rv[0]), 32'd1);
        check_eq("b2b_second_id", 32'(rsp_id[0]), 32'h11);
        check_eq("b2b_second_data", rd[0], 32'h2DFD_1072);
        @(posedge clk); #1;
        rr[0] = 1'b0;
        check_eq("b2b_done", 32'(rv[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cfu_crc_unit.md
CFU_CRC_UNIT -- requirements
Module: cfu_crc_unit

Interface
REQ-001 SHALL have parameter POLY, default 32'hEDB88320, reflected CRC-32 polynomial.
REQ-002 SHALL have parameter NBYTES, default 4, data bytes consumed per request (1..4).
REQ-003 SHALL have parameter BYTES_PER_CYCLE, default 1, bytes folded per clock (1, 2 or 4; must divide NBYTES).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfu  cfu_interface (unit side)  --  request/response channel; fields req_valid, req_ready, req_id, req_data0, req_data1, resp_valid, resp_ready, resp_id, resp_data, resp_status.
REQ-007 SHALL treat req_data0 as data word (bytes taken LSB first) and req_data1 as running CRC in.

Function
REQ-008 SHALL implement FSM IDLE -> CALC -> RESP -> IDLE.
REQ-009 IDLE: req_ready=1; on req_valid capture req_id, req_data0, req_data1, clear byte counter, go CALC.
REQ-010 CALC: per cycle fold BYTES_PER_CYCLE bytes, each as crc = TAB[(crc ^ byte) & 8'hFF] ^ (crc >> 8), byte order LSB first.
REQ-011 CALC: after NBYTES/BYTES_PER_CYCLE cycles go RESP; counter width clog2(NBYTES)+1, no wrap past NBYTES.
REQ-012 RESP: resp_valid=1, resp_data=final crc, resp_id=captured id, resp_status=0; all stable until resp_valid & resp_ready.
REQ-013 Latency: resp_valid rises NBYTES/BYTES_PER_CYCLE + 1 cycles after accepted request.
REQ-014 req_ready SHALL be 0 in CALC and RESP; requests presented then SHALL be ignored, not queued.
REQ-015 On handshake in RESP SHALL return to IDLE; req_ready SHALL rise the next cycle (no same-cycle accept).
REQ-016 resp_ready held low SHALL stall RESP indefinitely without data change.
REQ-017 TAB SHALL be a 256x32 constant generated at elaboration from POLY; no external hex file.
REQ-018 No final XOR or initial inversion; software owns init/final values.

Reset
REQ-019 rst low SHALL asynchronously force IDLE, resp_valid=0, resp_data=0, resp_id=0, resp_status=0, counter=0.
REQ-020 rst mid-CALC or mid-RESP SHALL abort the operation; no response SHALL ever be issued for it.
REQ-021 After rst release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-022 Shared package cfu_crc_pkg SHALL hold crc_state_t enum and function gen_crc_table(poly).
REQ-023 One sub-module cfu_crc_byte_fold (combinational, one byte, TAB lookup) SHALL be instantiated BYTES_PER_CYCLE times in a chain.
REQ-024 Parameter legality SHALL be checked at elaboration (assert NBYTES % BYTES_PER_CYCLE == 0).

Verification
REQ-025 NBYTES=1: data0=0x01, data1=0x00000000 -> resp_data=0x77073096, resp_valid 2 cycles after accept.
REQ-026 NBYTES=1: data0=0x00, data1=0xFFFFFFFF -> resp_data=0x2DFD1072.
REQ-027 NBYTES=1, nine chained requests "123456789" from 0xFFFFFFFF -> last resp_data=0x340BC6D9 (inverted 0xCBF43926); NBYTES=4/BYTES_PER_CYCLE=4 with words 0x34333231, 0x38373635 then NBYTES=1 for 0x39 -> same result.
REQ-028 resp_ready low 10 cycles in RESP, second req_valid pulsed -> req_ready stays 0, resp_data/resp_id unchanged, second request never answered.
REQ-029 rst low during CALC -> resp_valid=0 immediately, req_ready=1 first cycle after release, no stale response.
REQ-030 Back-to-back: req_valid held high across handshake -> new accept exactly one cycle after resp handshake, resp_id tracks each req_id.
